// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: memory-side input, write-back output and control bundle of mem_wb_stage; MEM_WB_FWD_EN adds forwarding query signals
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NSRC = 3,
  parameter int SEL_W = NSRC > 1 ? $clog2(NSRC) : 1
);
  logic in_valid;
  logic in_ready;
  logic in_regwrite;
  logic [SEL_W-1:0] in_wb_sel;
  logic [REG_AW-1:0] in_rd;
  logic [NSRC*DATA_W-1:0] in_src;
  logic flush;
  logic wb_stall;
  logic wb_valid;
  logic wb_en;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [1:0] occupancy;
`ifdef MEM_WB_FWD_EN
  logic [REG_AW-1:0] fwd_rs1;
  logic [REG_AW-1:0] fwd_rs2;
  logic fwd_hit1;
  logic fwd_hit2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;
`endif
  modport slave (
    input in_valid, in_regwrite, in_wb_sel, in_rd, in_src, flush, wb_stall,
    output in_ready, wb_valid, wb_en, wb_rd, wb_data, occupancy
`ifdef MEM_WB_FWD_EN
    , input fwd_rs1, fwd_rs2
    , output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
  );
  modport master (
    output in_valid, in_regwrite, in_wb_sel, in_rd, in_src, flush, wb_stall,
    input in_ready, wb_valid, wb_en, wb_rd, wb_data, occupancy
`ifdef MEM_WB_FWD_EN
    , output fwd_rs1, fwd_rs2
    , input fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB stage with valid/ready, 2-entry skid buffer, flush and N-way write-back select (clk, rst, bus slave); MEM_WB_FWD_EN adds forwarding
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int NSRC = 3
) (
  input logic clk,
  input logic rst,
  mem_wb_stage_if.slave bus
);
  typedef struct packed {
    logic v;
    logic rw;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;
  ent_t h_q, h_d, s_q, s_d, inc;
  logic [1:0] occ_q, occ_d;
  logic [DATA_W-1:0] sel_data;
  logic acc, con;
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NSRC; k++)
      if (int'(bus.in_wb_sel) == k) sel_data = bus.in_src[k*DATA_W +: DATA_W];
    inc = {1'b1, bus.in_regwrite, bus.in_rd, sel_data};
    acc = bus.in_valid & ~s_q.v & ~bus.flush;
    con = h_q.v & ~bus.wb_stall;
    h_d = h_q;
    s_d = s_q;
    if (bus.flush) begin
      h_d.v = 1'b0;
      s_d.v = 1'b0;
    end else if (con && s_q.v) begin
      h_d = s_q;
      s_d.v = 1'b0;
    end else if (con || !h_q.v) begin
      h_d = acc ? inc : h_q;
      h_d.v = acc;
    end else if (acc) begin
      s_d = inc;
    end
    occ_d = 2'(h_d.v) + 2'(s_d.v);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      s_q <= '0;
      occ_q <= '0;
    end else begin
      h_q <= h_d;
      s_q <= s_d;
      occ_q <= occ_d;
    end
  end
  assign bus.in_ready = ~s_q.v;
  assign bus.wb_valid = h_q.v;
  assign bus.wb_en = h_q.v & h_q.rw & |h_q.rd;
  assign bus.wb_rd = h_q.rd;
  assign bus.wb_data = h_q.data;
  assign bus.occupancy = occ_q;
`ifdef MEM_WB_FWD_EN
  function automatic logic [DATA_W:0] fwd(input logic [REG_AW-1:0] rs, input ent_t h, input ent_t s);
    logic hs, hh;
    hs = s.v & s.rw & |s.rd & (s.rd == rs);
    hh = h.v & h.rw & |h.rd & (h.rd == rs);
    return hs ? {1'b1, s.data} : hh ? {1'b1, h.data} : '0;
  endfunction
  assign {bus.fwd_hit1, bus.fwd_data1} = fwd(bus.fwd_rs1, h_q, s_q);
  assign {bus.fwd_hit2, bus.fwd_data2} = fwd(bus.fwd_rs2, h_q, s_q);
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and randomized checks of mem_wb_stage against a queue model
module tb_mem_wb_stage;
  typedef struct {
    logic rw;
    logic [4:0] rd;
    logic [31:0] data;
  } ent_t;
  logic clk = 0;
  logic rst = 1;
  logic [31:0] src [3];
  ent_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  mem_wb_stage_if bus ();
  mem_wb_stage dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.in_src = {src[2], src[1], src[0]};
  always #5 clk = ~clk;
  task automatic step();
    bit rdy;
    ent_t e;
    @(posedge clk);
    rdy = q.size() < 2;
    e.rw = bus.in_regwrite;
    e.rd = bus.in_rd;
    e.data = bus.in_wb_sel < 3 ? src[bus.in_wb_sel] : 32'h0;
    if (rst || bus.flush) q.delete();
    else begin
      if (q.size() > 0 && !bus.wb_stall) void'(q.pop_front());
      if (bus.in_valid && rdy) q.push_back(e);
    end
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    step();
    step();
    n_cmp += 6;
    if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wb_valid got %b want 0", bus.wb_valid); end
    if (bus.wb_en !== 1'b0) begin n_bad++; $display("FAIL reset_wb_en got %b want 0", bus.wb_en); end
    if (bus.wb_rd !== 5'd0) begin n_bad++; $display("FAIL reset_wb_rd got %h want 0", bus.wb_rd); end
    if (bus.wb_data !== 32'h0) begin n_bad++; $display("FAIL reset_wb_data got %h want 0", bus.wb_data); end
    if (bus.occupancy !== 2'd0) begin n_bad++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    rst = 0;
    step();
  endtask
  task automatic test_stream();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC; exp_d[3] = 32'hA;
    src[0] = 32'hA; src[1] = 32'hB; src[2] = 32'hC;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1;
      bus.in_regwrite = 1;
      bus.in_rd = 5'(i + 1);
      bus.in_wb_sel = i == 3 ? 2'd0 : 2'(i);
      step();
      n_cmp += 4;
      if (bus.wb_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d] got %b want 1", i, bus.wb_valid); end
      if (bus.wb_data !== exp_d[i]) begin n_bad++; $display("FAIL stream_data[%0d] got %h want %h", i, bus.wb_data, exp_d[i]); end
      if (bus.wb_en !== 1'b1) begin n_bad++; $display("FAIL stream_en[%0d] got %b want 1", i, bus.wb_en); end
      if (bus.wb_rd !== 5'(i + 1)) begin n_bad++; $display("FAIL stream_rd[%0d] got %0d want %0d", i, bus.wb_rd, i + 1); end
    end
    bus.in_valid = 0;
    step();
    n_cmp += 2;
    if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain_valid got %b want 0", bus.wb_valid); end
    if (bus.occupancy !== 2'd0) begin n_bad++; $display("FAIL stream_drain_occ got %0d want 0", bus.occupancy); end
  endtask
  task automatic test_stall();
    logic [31:0] x [3];
    logic [31:0] got[$];
    int sent = 0;
    bit acc;
    for (int i = 0; i < 3; i++) x[i] = $urandom;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) begin
        n_cmp += 3;
        if (bus.occupancy !== 2'd2) begin n_bad++; $display("FAIL stall_occ got %0d want 2", bus.occupancy); end
        if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got %b want 0", bus.in_ready); end
        if (bus.wb_data !== x[0]) begin n_bad++; $display("FAIL stall_head got %h want %h", bus.wb_data, x[0]); end
      end
      bus.wb_stall = c < 3;
      bus.in_valid = sent < 3;
      bus.in_regwrite = 1;
      bus.in_wb_sel = 0;
      bus.in_rd = 5'(sent + 1);
      src[0] = sent < 3 ? x[sent] : 32'h0;
      #1;
      if (bus.wb_valid && !bus.wb_stall) got.push_back(bus.wb_data);
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) sent++;
    end
    n_cmp++;
    if (got.size() !== 3) begin n_bad++; $display("FAIL stall_count got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== x[i]) begin n_bad++; $display("FAIL stall_order[%0d] got %h want %h", i, got[i], x[i]); end
    end
  endtask
  task automatic test_flush();
    bus.wb_stall = 1;
    bus.in_valid = 1;
    bus.in_wb_sel = 0;
    bus.in_rd = 5'd9;
    src[0] = 32'h1111;
    step();
    src[0] = 32'h2222;
    step();
    n_cmp++;
    if (bus.occupancy !== 2'd2) begin n_bad++; $display("FAIL flush_pre_occ got %0d want 2", bus.occupancy); end
    bus.flush = 1;
    src[0] = 32'hDEAD;
    step();
    bus.flush = 0;
    bus.in_valid = 0;
    bus.wb_stall = 0;
    n_cmp += 3;
    if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b want 0", bus.wb_valid); end
    if (bus.occupancy !== 2'd0) begin n_bad++; $display("FAIL flush_occ got %0d want 0", bus.occupancy); end
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready got %b want 1", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ghost[%0d] got valid %b data %h want 0", i, bus.wb_valid, bus.wb_data); end
    end
  endtask
  task automatic test_edges();
    bus.in_valid = 1;
    bus.in_regwrite = 1;
    bus.in_rd = 0;
    bus.in_wb_sel = 0;
    src[0] = 32'h55;
    step();
    n_cmp += 3;
    if (bus.wb_valid !== 1'b1) begin n_bad++; $display("FAIL rd0_valid got %b want 1", bus.wb_valid); end
    if (bus.wb_en !== 1'b0) begin n_bad++; $display("FAIL rd0_en got %b want 0", bus.wb_en); end
    if (bus.wb_data !== 32'h55) begin n_bad++; $display("FAIL rd0_data got %h want 55", bus.wb_data); end
    bus.in_rd = 7;
    bus.in_wb_sel = 3;
    src[0] = 32'h66; src[1] = 32'h77; src[2] = 32'h88;
    step();
    n_cmp += 3;
    if (bus.wb_data !== 32'h0) begin n_bad++; $display("FAIL sel3_data got %h want 0", bus.wb_data); end
    if (bus.wb_en !== 1'b1) begin n_bad++; $display("FAIL sel3_en got %b want 1", bus.wb_en); end
    if (bus.wb_rd !== 5'd7) begin n_bad++; $display("FAIL sel3_rd got %0d want 7", bus.wb_rd); end
    bus.in_regwrite = 0;
    bus.in_rd = 5;
    bus.in_wb_sel = 1;
    step();
    n_cmp += 2;
    if (bus.wb_en !== 1'b0) begin n_bad++; $display("FAIL norw_en got %b want 0", bus.wb_en); end
    if (bus.wb_data !== 32'h77) begin n_bad++; $display("FAIL norw_data got %h want 77", bus.wb_data); end
    bus.in_valid = 0;
    step();
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = $urandom_range(0, 99) == 0;
      bus.flush = $urandom_range(0, 19) == 0;
      bus.wb_stall = $urandom_range(0, 9) < 3;
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.in_regwrite = 1'($urandom);
      bus.in_rd = 5'($urandom_range(0, 7));
      bus.in_wb_sel = 2'($urandom);
      for (int k = 0; k < 3; k++) src[k] = $urandom;
      step();
      n_cmp += 3;
      if (bus.in_ready !== (q.size() < 2)) begin n_bad++; $display("FAIL rnd_in_ready[%0d] got %b want %b", c, bus.in_ready, q.size() < 2); end
      if (bus.wb_valid !== (q.size() > 0)) begin n_bad++; $display("FAIL rnd_valid[%0d] got %b want %b", c, bus.wb_valid, q.size() > 0); end
      if (bus.occupancy !== 2'(q.size())) begin n_bad++; $display("FAIL rnd_occ[%0d] got %0d want %0d", c, bus.occupancy, q.size()); end
      if (q.size() > 0) begin
        n_cmp += 3;
        if (bus.wb_rd !== q[0].rd) begin n_bad++; $display("FAIL rnd_rd[%0d] got %0d want %0d", c, bus.wb_rd, q[0].rd); end
        if (bus.wb_data !== q[0].data) begin n_bad++; $display("FAIL rnd_data[%0d] got %h want %h", c, bus.wb_data, q[0].data); end
        if (bus.wb_en !== (q[0].rw && q[0].rd != 0)) begin n_bad++; $display("FAIL rnd_en[%0d] got %b want %b", c, bus.wb_en, q[0].rw && q[0].rd != 0); end
      end
    end
    rst = 0;
    bus.flush = 0;
    bus.wb_stall = 0;
    bus.in_valid = 0;
    step();
    step();
    step();
  endtask
`ifdef MEM_WB_FWD_EN
  task automatic test_fwd();
    bus.wb_stall = 1;
    bus.in_valid = 1;
    bus.in_regwrite = 1;
    bus.in_rd = 5;
    bus.in_wb_sel = 0;
    src[0] = 32'h11;
    step();
    bus.fwd_rs1 = 5;
    #1;
    n_cmp += 2;
    if (bus.fwd_hit1 !== 1'b1) begin n_bad++; $display("FAIL fwd_h_hit got %b want 1", bus.fwd_hit1); end
    if (bus.fwd_data1 !== 32'h11) begin n_bad++; $display("FAIL fwd_h_data got %h want 11", bus.fwd_data1); end
    src[0] = 32'h22;
    step();
    bus.in_valid = 0;
    bus.fwd_rs2 = 6;
    #1;
    n_cmp += 4;
    if (bus.fwd_hit1 !== 1'b1) begin n_bad++; $display("FAIL fwd_hit1 got %b want 1", bus.fwd_hit1); end
    if (bus.fwd_data1 !== 32'h22) begin n_bad++; $display("FAIL fwd_data1 got %h want 22", bus.fwd_data1); end
    if (bus.fwd_hit2 !== 1'b0) begin n_bad++; $display("FAIL fwd_hit2 got %b want 0", bus.fwd_hit2); end
    if (bus.fwd_data2 !== 32'h0) begin n_bad++; $display("FAIL fwd_data2 got %h want 0", bus.fwd_data2); end
    bus.wb_stall = 0;
    step();
    step();
    step();
  endtask
`endif
  initial begin
    bus.in_valid = 0;
    bus.in_regwrite = 0;
    bus.in_wb_sel = 0;
    bus.in_rd = 0;
    bus.flush = 0;
    bus.wb_stall = 0;
    for (int k = 0; k < 3; k++) src[k] = 0;
`ifdef MEM_WB_FWD_EN
    bus.fwd_rs1 = 0;
    bus.fwd_rs2 = 0;
`endif
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_edges();
    test_random();
`ifdef MEM_WB_FWD_EN
    test_fwd();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
